// File: rtl/fft_ctrl.sv
// fft_ctrl: address/sequence controller for an in-place radix-2 DIT FFT.
// Latency: load N samples, LOG2N stages of N/2 butterflies each with a drain, N unload reads, 1-cycle done.
// Backpressure: in_valid/in_ready on load, bfly_valid/bfly_ready on issue, rd_valid/rd_ready on unload.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start / busy / done        transform request, activity flag, completion pulse
//   in_valid / in_ready        sample load handshake; mem_we + wr_addr (bit-reversed) write the sample
//   bfly_valid / bfly_ready    butterfly issue handshake; addr_a, addr_b, tw_idx, stage describe it
//   bfly_wb                    one butterfly result pair written back
//   rd_valid / rd_ready        unload handshake; rd_addr (natural order), rd_last on the final read
module fft_ctrl #(
  parameter int N     = 8,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_we,
  output logic [LOG2N-1:0] wr_addr,
  output logic             bfly_valid,
  input  logic             bfly_ready,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [LOG2N-1:0] stage,
  input  logic             bfly_wb,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [LOG2N-1:0] rd_addr,
  output logic             rd_last
);

  localparam int AW = LOG2N;
  localparam logic [AW-1:0] CNT_MAX   = AW'(N - 1);
  localparam logic [AW-2:0] B_MAX     = (AW-1)'(N / 2 - 1);
  localparam logic [AW-1:0] STAGE_MAX = AW'(LOG2N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, COMP, DRAIN, UNLOAD, FIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;        // load / unload sample counter
  logic [AW-2:0] b, b_nxt;            // butterfly issue index within a stage
  logic [AW-1:0] stage_r, stage_nxt;
  logic [AW-1:0] outst;               // butterflies issued but not yet written back
  logic          clr_outst;

  logic [AW-1:0] cnt_rev;
  logic [AW-1:0] b_ext, h, j, g, a_calc, tw_full;
  logic          issue, wb_eff;

  // Bit-reversed load address
  always_comb begin
    cnt_rev = '0;
    for (int i = 0; i < AW; i++) begin
      cnt_rev[i] = cnt[AW-1-i];
    end
  end

  // Butterfly operand addressing: group g of span 2h, offset j inside the group
  always_comb begin
    b_ext   = {1'b0, b};
    h       = AW'(1) << stage_r;
    j       = b_ext & (h - AW'(1));
    g       = b_ext >> stage_r;
    a_calc  = (g << (stage_r + 1)) | j;
    tw_full = j << (STAGE_MAX - stage_r);
  end

  assign issue  = bfly_valid & bfly_ready;
  // A write-back with nothing outstanding is spurious and must not wrap the counter
  assign wb_eff = bfly_wb & (outst != '0);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    b_nxt      = b;
    stage_nxt  = stage_r;
    clr_outst  = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    wr_addr    = '0;
    bfly_valid = 1'b0;
    addr_a     = '0;
    addr_b     = '0;
    tw_idx     = '0;
    stage      = '0;
    rd_valid   = 1'b0;
    rd_addr    = '0;
    rd_last    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
          b_nxt     = '0;
          stage_nxt = '0;
          clr_outst = 1'b1;
        end
      end

      LOAD: begin
        in_ready = 1'b1;
        mem_we   = in_valid;
        wr_addr  = cnt_rev;
        if (in_valid) begin
          cnt_nxt = cnt + AW'(1);
          if (cnt == CNT_MAX) begin
            state_nxt = COMP;
            cnt_nxt   = '0;
            b_nxt     = '0;
            stage_nxt = '0;
          end
        end
      end

      COMP: begin
        bfly_valid = 1'b1;
        addr_a     = a_calc;
        addr_b     = a_calc | h;
        tw_idx     = tw_full[AW-2:0];
        stage      = stage_r;
        if (bfly_ready) begin
          if (b == B_MAX) begin
            state_nxt = DRAIN;
            b_nxt     = '0;
          end else begin
            b_nxt = b + (AW-1)'(1);
          end
        end
      end

      DRAIN: begin
        stage = stage_r;
        // Next stage reads results of this one, so wait for every write-back
        if ((outst == '0) && !bfly_wb) begin
          if (stage_r == STAGE_MAX) begin
            state_nxt = UNLOAD;
            cnt_nxt   = '0;
          end else begin
            state_nxt = COMP;
            stage_nxt = stage_r + AW'(1);
            b_nxt     = '0;
          end
        end
      end

      UNLOAD: begin
        rd_valid = 1'b1;
        rd_addr  = cnt;
        rd_last  = (cnt == CNT_MAX);
        if (rd_ready) begin
          cnt_nxt = cnt + AW'(1);
          if (cnt == CNT_MAX) begin
            state_nxt = FIN;
            cnt_nxt   = '0;
          end
        end
      end

      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      b       <= '0;
      stage_r <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      b       <= b_nxt;
      stage_r <= stage_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else if (clr_outst) begin
      outst <= '0;
    end else if (issue && !wb_eff) begin
      outst <= outst + AW'(1);
    end else if (!issue && wb_eff) begin
      outst <= outst - AW'(1);
    end
  end

endmodule

// File: tb/tb_fft_ctrl.sv
// tb_fft_ctrl: directed and randomized transforms against a sequential reference model.
module tb_fft_ctrl;
  localparam int N     = 8;
  localparam int LOG2N = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, in_valid, bfly_ready, bfly_wb, rd_ready;
  logic             busy, done, in_ready, mem_we, bfly_valid, rd_valid, rd_last;
  logic [LOG2N-1:0] wr_addr, addr_a, addr_b, stage, rd_addr;
  logic [LOG2N-2:0] tw_idx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int wbq[$];
  int pa[$], pb[$], pt[$];

  always #5 clk = ~clk;

  fft_ctrl #(.N(N), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we), .wr_addr(wr_addr),
    .bfly_valid(bfly_valid), .bfly_ready(bfly_ready), .addr_a(addr_a), .addr_b(addr_b),
    .tw_idx(tw_idx), .stage(stage), .bfly_wb(bfly_wb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_last(rd_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL timeout %s: observed no progress expected completion", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic int rev(input int v);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if (v[i]) r |= (1 << (LOG2N - 1 - i));
    return r;
  endfunction

  // Butterfly list of one stage in issue order: groups of span 2h, twiddle exponent j*N/(2h)
  task automatic build(input int s);
    int h;
    h = 1 << s;
    pa.delete(); pb.delete(); pt.delete();
    for (int base = 0; base < N; base += 2 * h)
      for (int jj = 0; jj < h; jj++) begin
        pa.push_back(base + jj);
        pb.push_back(base + jj + h);
        pt.push_back(jj * (N / (2 * h)));
      end
  endtask

  task automatic drive_wb();
    bfly_wb = 1'b0;
    if (wbq.size() > 0 && wbq[0] <= cyc) begin
      bfly_wb = 1'b1;
      void'(wbq.pop_front());
    end
  endtask

  function automatic logic [31:0] all_out();
    return {8'd0, busy, done, in_ready, mem_we, wr_addr, bfly_valid, addr_a, addr_b,
            tw_idx, stage, rd_valid, rd_addr, rd_last};
  endfunction

  task automatic run_transform(input bit directed);
    int  k, guard, idx, stall, d, pre;
    bit  tog, fin;
    start = 1'b1;
    #1 chk("idle_busy", 32'(busy), 0);
    chk("idle_in_ready", 32'(in_ready), 0);
    tick();
    start = 1'b0;
    // load
    k = 0; guard = 0;
    while (k < N) begin
      if (guard++ >= 200) begin timeout("load"); break; end
      in_valid = directed ? 1'b1 : 1'($urandom_range(0, 1));
      #1 chk("load_in_ready", 32'(in_ready), 1);
      chk("load_busy", 32'(busy), 1);
      chk("load_mem_we", 32'(mem_we), 32'(in_valid));
      if (in_valid) chk("load_wr_addr", 32'(wr_addr), rev(k));
      chk("load_bfly_valid", 32'(bfly_valid), 0);
      tick();
      if (in_valid) k++;
    end
    in_valid = 1'b0;
    // butterfly stages
    for (int s = 0; s < LOG2N; s++) begin
      build(s);
      idx = 0; stall = 0; guard = 0;
      while (idx < N / 2) begin
        if (guard++ >= 200) begin timeout("comp"); break; end
        if (directed) bfly_ready = !(s == 1 && idx == 2 && stall < 3);
        else          bfly_ready = ($urandom_range(0, 3) != 0);
        start = 1'($urandom_range(0, 3) == 0);
        drive_wb();
        #1 chk("comp_bfly_valid", 32'(bfly_valid), 1);
        chk("comp_addr_a", 32'(addr_a), pa[idx]);
        chk("comp_addr_b", 32'(addr_b), pb[idx]);
        chk("comp_tw_idx", 32'(tw_idx), pt[idx]);
        chk("comp_stage", 32'(stage), s);
        chk("comp_in_ready", 32'(in_ready), 0);
        chk("comp_rd_valid", 32'(rd_valid), 0);
        if (bfly_ready) begin
          if (directed) d = (s == 0 && idx == N / 2 - 1) ? 6 : 1;
          else          d = $urandom_range(1, 4);
          wbq.push_back(cyc + d);
          idx++;
        end else begin
          stall++;
        end
        tick();
      end
      // drain: no issue until every write-back has arrived
      guard = 0; fin = 1'b0;
      while (!fin) begin
        if (guard++ >= 200) begin timeout("drain"); break; end
        bfly_ready = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 3) == 0);
        pre = wbq.size();
        drive_wb();
        #1 chk("drain_bfly_valid", 32'(bfly_valid), 0);
        chk("drain_stage", 32'(stage), s);
        chk("drain_busy", 32'(busy), 1);
        tick();
        fin = (pre == 0);
      end
    end
    start = 1'b0; bfly_ready = 1'b0; bfly_wb = 1'b0;
    // unload
    k = 0; guard = 0; tog = 1'b1;
    while (k < N) begin
      if (guard++ >= 200) begin timeout("unload"); break; end
      rd_ready = directed ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      #1 chk("unload_rd_valid", 32'(rd_valid), 1);
      chk("unload_rd_addr", 32'(rd_addr), k);
      chk("unload_rd_last", 32'(rd_last), 32'(k == N - 1));
      chk("unload_bfly_valid", 32'(bfly_valid), 0);
      tick();
      if (rd_ready) k++;
    end
    rd_ready = 1'b0;
    #1 chk("fin_done", 32'(done), 1);
    chk("fin_busy", 32'(busy), 1);
    chk("fin_rd_valid", 32'(rd_valid), 0);
    tick();
    #1 chk("idle_done", 32'(done), 0);
    chk("idle_busy_after", 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; bfly_ready = 1'b0;
    bfly_wb = 1'b0; rd_ready = 1'b0;
    #1 chk("reset_outputs", all_out(), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // directed transform: bit-reversed load, address tables, stall, delayed write-back, toggled unload
    run_transform(1'b1);

    // abort mid-COMP with asynchronous reset
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    repeat (N) tick();
    in_valid = 1'b0;
    bfly_ready = 1'b1;
    repeat (2) tick();
    #1 chk("pre_abort_bfly_valid", 32'(bfly_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk("abort_outputs", all_out(), 0);
    bfly_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wbq.delete();

    // first start after reset is accepted immediately; then randomized transforms
    for (int t = 0; t < 4; t++) run_transform(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter N, default 8; FFT size, power of 2, 4..1024.
REQ-002 Parameter LOG2N, default 3; log2(N); AW = LOG2N is the address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  begin a transform; sampled only in IDLE.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 in_valid  input  1  input sample valid.
REQ-009 in_ready  output  1  controller accepts an input sample.
REQ-010 mem_we  output  1  sample-memory write strobe.
REQ-011 wr_addr  output  AW  bit-reversed write address.
REQ-012 bfly_valid  output  1  butterfly issue request.
REQ-013 bfly_ready  input  1  butterfly unit accepts an issue.
REQ-014 addr_a  output  AW  butterfly top operand address.
REQ-015 addr_b  output  AW  butterfly bottom operand address.
REQ-016 tw_idx  output  AW-1  twiddle LUT index, range 0..N/2-1.
REQ-017 stage  output  AW  current stage number, 0..LOG2N-1.
REQ-018 bfly_wb  input  1  butterfly unit has written back one result pair.
REQ-019 rd_valid  output  1  unload read request.
REQ-020 rd_ready  input  1  downstream accepts the read request.
REQ-021 rd_addr  output  AW  natural-order read address.
REQ-022 rd_last  output  1  marks the final read, where rd_addr = N-1.

Function
REQ-023 The FSM SHALL have the states IDLE, LOAD, COMP, DRAIN, UNLOAD and FIN.
REQ-024 IDLE: when start=1, the FSM SHALL enter LOAD on the next cycle and clear all counters; start SHALL be ignored in every other state.
REQ-025 LOAD: in_ready=1; mem_we = in_valid & in_ready; wr_addr = bit-reverse(cnt) over AW bits; cnt increments on each accepted sample.
REQ-026 When the N-th sample is accepted, the FSM SHALL enter COMP with stage=0 and b=0; in_ready=0 outside LOAD.
REQ-027 COMP: bfly_valid=1. With h = 1<<stage, j = b & (h-1) and g = b>>stage: addr_a = 2*h*g + j, addr_b = addr_a + h, tw_idx = j << (LOG2N-1-stage).
REQ-028 The issue index b, 0..N/2-1, SHALL advance only on bfly_valid & bfly_ready; while bfly_ready=0, all issue outputs SHALL hold stable.
REQ-029 An outstanding counter (AW bits) SHALL count +1 per issue and -1 per bfly_wb; a simultaneous issue and bfly_wb SHALL leave it unchanged.
REQ-030 After the issue with b = N/2-1 is accepted, the FSM SHALL enter DRAIN with bfly_valid=0.
REQ-031 DRAIN: once the outstanding count is 0 and bfly_wb=0 in the current cycle, the FSM SHALL go to COMP with stage+1 and b=0, or to UNLOAD if stage = LOG2N-1.
REQ-032 A bfly_wb arriving when the outstanding count is 0 SHALL be ignored; the counter SHALL NOT underflow.
REQ-033 UNLOAD: rd_valid=1; rd_addr = cnt, from 0 to N-1; cnt advances on rd_valid & rd_ready; rd_last = rd_valid & (cnt = N-1).
REQ-034 On acceptance of the rd_last transfer, the FSM SHALL enter FIN; FIN SHALL assert done=1 for one cycle and then return to IDLE.
REQ-035 Outputs for inactive phases SHALL be 0: mem_we, bfly_valid, rd_valid and all address outputs are 0 outside their own state.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE, clear all counters and drive every output to 0, including during an active transform; the aborted transform is discarded.
REQ-037 After rst_n deasserts, the first start SHALL be accepted on the first clock edge.

Verification (N=8)
REQ-038 Reset: assert rst_n=0 mid-COMP -> all outputs 0 with no clock; after release, busy=0 and start is accepted.
REQ-039 Load: 8 back-to-back samples -> wr_addr sequence 0,4,2,6,1,5,3,7; entry into COMP on the cycle after the 8th sample.
REQ-040 Addresses, with bfly_ready=1 and bfly_wb returned 1 cycle after each issue:
- stage0: pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0;
- stage1: pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2;
- stage2: pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
REQ-041 Backpressure: bfly_ready=0 for 3 cycles at b=2 of stage1 -> addr_a=4, addr_b=6, tw_idx=0 held for 3 cycles, with no extra issue.
REQ-042 Drain: final stage0 bfly_wb delayed by 5 cycles -> no stage1 issue before the outstanding count reaches 0; start pulses during COMP are ignored.
REQ-043 Unload: rd_ready toggled 1,0,1... -> rd_addr 0..7 each transferred once, rd_last only with 7, a done pulse 1 cycle after that transfer, then busy=0.
